alu_serial_ctrl: RTL and testbench



---
 rtl/alu_serial_ctrl_pkg.sv | 57 +++++
 rtl/alu_serial_ctrl_if.sv | 25 ++
 rtl/alu_bit_slice.sv | 29 ++
 rtl/alu_serial_ctrl.sv | 122 ++++++++++++
 tb/tb_alu_serial_ctrl.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/alu_serial_ctrl_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: funct codes, slice ops,
// FSM states and the funct-to-slice-control decoder.
package alu_serial_ctrl_pkg;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_SUM = 2'b10
  } slice_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    FINISH = 2'b10
  } state_e;

  typedef struct packed {
    logic      ainv;
    logic      binv;
    logic      cin;
    slice_op_e op;
    logic      slt;
    logic      ovf_en;
  } ctrl_t;

  function automatic logic funct_legal(logic [5:0] f);
    logic ok;
    case (f)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT: ok = 1'b1;
      default:                                       ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic ctrl_t decode_funct(logic [5:0] f);
    ctrl_t c;
    c = '{ainv: 1'b0, binv: 1'b0, cin: 1'b0, op: OP_AND, slt: 1'b0, ovf_en: 1'b0};
    case (f)
      FN_ADD: begin c.op = OP_SUM; c.ovf_en = 1'b1; end
      FN_SUB: begin c.binv = 1'b1; c.cin = 1'b1; c.op = OP_SUM; c.ovf_en = 1'b1; end
      FN_AND: c.op = OP_AND;
      FN_OR:  c.op = OP_OR;
      FN_NOR: begin c.ainv = 1'b1; c.binv = 1'b1; c.op = OP_AND; end
      FN_SLT: begin c.binv = 1'b1; c.cin = 1'b1; c.op = OP_SUM; c.slt = 1'b1; end
      default: c.op = OP_AND;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_serial_ctrl_if.sv
// Request/response bundle between R-type decode and the serial ALU sequencer.
interface alu_serial_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [5:0]       funct;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             illegal;

  modport master (
    output start, funct, a, b,
    input  busy, done, result, zero, overflow, illegal
  );

  modport slave (
    input  start, funct, a, b,
    output busy, done, result, zero, overflow, illegal
  );
endinterface

// File: rtl/alu_bit_slice.sv
// Combinational 1-bit ALU slice: optional A/B inversion, full adder, op mux.
module alu_bit_slice
  import alu_serial_ctrl_pkg::*;
(
  input  logic      a_i,
  input  logic      b_i,
  input  logic      ainv_i,
  input  logic      binv_i,
  input  logic      cin_i,
  input  slice_op_e op_i,
  output logic      res_o,
  output logic      cout_o
);

  logic aa, bb;

  always_comb begin
    aa     = a_i ^ ainv_i;
    bb     = b_i ^ binv_i;
    cout_o = (aa & bb) | (cin_i & (aa ^ bb));
    case (op_i)
      OP_AND:  res_o = aa & bb;
      OP_OR:   res_o = aa | bb;
      OP_SUM:  res_o = aa ^ bb ^ cin_i;
      default: res_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: decodes funct, walks one slice LSB-first over WIDTH
// cycles with a registered carry, then publishes result, zero, overflow, illegal.
module alu_serial_ctrl
  import alu_serial_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_serial_ctrl_if.slave  bus_io
);

  localparam int unsigned    CntW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic [WIDTH-2:0] sh_q;
  ctrl_t            ctrl_q;
  logic             busy_q, done_q, zero_q, ovf_q, illegal_q;

  ctrl_t            dec;
  logic             dec_legal;
  logic             s_res, s_cout, ovf_raw, ovf_fin;
  logic [WIDTH-1:0] sum_word, fin_word;

  always_comb begin
    dec       = decode_funct(bus_io.funct);
    dec_legal = funct_legal(bus_io.funct);
  end

  alu_bit_slice u_slice (
    .a_i    (a_q[cnt_q]),
    .b_i    (b_q[cnt_q]),
    .ainv_i (ctrl_q.ainv),
    .binv_i (ctrl_q.binv),
    .cin_i  (carry_q),
    .op_i   (ctrl_q.op),
    .res_o  (s_res),
    .cout_o (s_cout)
  );

  // Only meaningful on the MSB cycle, where carry_q is the carry into the MSB.
  always_comb begin
    sum_word = {s_res, sh_q};
    ovf_raw  = carry_q ^ s_cout;
    ovf_fin  = ctrl_q.ovf_en & ovf_raw;
    fin_word = sum_word;
    if (ctrl_q.slt) fin_word = {{(WIDTH-1){1'b0}}, s_res ^ ovf_raw};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sh_q      <= '0;
      result_q  <= '0;
      ctrl_q    <= '{ainv: 1'b0, binv: 1'b0, cin: 1'b0, op: OP_AND, slt: 1'b0, ovf_en: 1'b0};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus_io.start) begin
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b1;
            if (dec_legal) begin
              a_q       <= bus_io.a;
              b_q       <= bus_io.b;
              ctrl_q    <= dec;
              carry_q   <= dec.cin;
              cnt_q     <= '0;
              illegal_q <= 1'b0;
              state_q   <= RUN;
            end else begin
              illegal_q <= 1'b1;
              done_q    <= 1'b1;
              state_q   <= FINISH;
            end
          end
        end
        RUN: begin
          sh_q    <= (WIDTH-1)'({s_res, sh_q} >> 1);
          carry_q <= s_cout;
          if (cnt_q == CntMax) begin
            result_q <= fin_word;
            zero_q   <= (fin_word == '0);
            ovf_q    <= ovf_fin;
            done_q   <= 1'b1;
            state_q  <= FINISH;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        FINISH: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_io.busy     = busy_q;
  assign bus_io.done     = done_q;
  assign bus_io.result   = result_q;
  assign bus_io.zero     = zero_q;
  assign bus_io.overflow = ovf_q;
  assign bus_io.illegal  = illegal_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed-vector bench for alu_serial_ctrl with hand-computed expectations.
module tb_alu_serial_ctrl;
  import alu_serial_ctrl_pkg::*;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  alu_serial_ctrl_if #(.WIDTH(32)) bus ();

  alu_serial_ctrl #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        o;
    logic        il;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called #1 after a clock edge; returns in the done cycle (or after a timeout).
  task automatic run_op(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv,
                        output int lat, output int nbusy, output logic ill1,
                        output logic [31:0] res1);
    bus.start = 1'b1;
    bus.funct = f;
    bus.a     = av;
    bus.b     = bv;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat   = 0;
    nbusy = 0;
    ill1  = bus.illegal;
    res1  = bus.result;
    for (int k = 1; k <= 100; k++) begin
      if (bus.busy) nbusy++;
      if (bus.done) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int          lat, nbusy, ndone;
    logic        ill1;
    logic [31:0] res1, rdone;

    n_vec = 0;
    n_err = 0;
    vecs[0]  = '{FN_ADD, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0, 1'b0, 33};
    vecs[1]  = '{FN_SUB, 32'h7FFF_FFFF,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0, 1'b1, 1'b0, 33};
    vecs[2]  = '{FN_SUB, 32'd5,          32'd5,          32'd0,          1'b1, 1'b0, 1'b0, 33};
    vecs[3]  = '{FN_SLT, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1'b0, 1'b0, 33};
    vecs[4]  = '{FN_SLT, 32'h8000_0000,  32'd1,          32'd1,          1'b0, 1'b0, 1'b0, 33};
    vecs[5]  = '{FN_SLT, 32'd1,          32'hFFFF_FFFF,  32'd0,          1'b1, 1'b0, 1'b0, 33};
    vecs[6]  = '{FN_NOR, 32'd0,          32'd0,          32'hFFFF_FFFF,  1'b0, 1'b0, 1'b0, 33};
    vecs[7]  = '{FN_AND, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000,  1'b0, 1'b0, 1'b0, 33};
    vecs[8]  = '{FN_OR,  32'h0000_000F,  32'h0000_00F0,  32'h0000_00FF,  1'b0, 1'b0, 1'b0, 33};
    vecs[9]  = '{6'b000000, 32'd5,       32'd5,          32'd0,          1'b0, 1'b0, 1'b1, 1};
    vecs[10] = '{FN_ADD, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b0, 1'b0, 33};
    vecs[11] = '{FN_ADD, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  1'b0, 1'b1, 1'b0, 33};

    bus.start = 1'b0;
    bus.funct = '0;
    bus.a     = '0;
    bus.b     = '0;
    rst_n     = 1'b0;
    #12;
    check("rst_busy",    32'(bus.busy),     32'd0);
    check("rst_done",    32'(bus.done),     32'd0);
    check("rst_result",  bus.result,        32'd0);
    check("rst_zero",    32'(bus.zero),     32'd0);
    check("rst_ovf",     32'(bus.overflow), 32'd0);
    check("rst_illegal", 32'(bus.illegal),  32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, lat, nbusy, ill1, res1);
      check($sformatf("v%0d_latency", i), 32'(lat),          32'(vecs[i].lat));
      check($sformatf("v%0d_busy_n", i),  32'(nbusy),        32'(vecs[i].lat));
      check($sformatf("v%0d_clr_res", i), res1,              32'd0);
      check($sformatf("v%0d_ill_acc", i), 32'(ill1),         32'(vecs[i].il));
      check($sformatf("v%0d_result", i),  bus.result,        vecs[i].res);
      check($sformatf("v%0d_zero", i),    32'(bus.zero),     32'(vecs[i].z));
      check($sformatf("v%0d_ovf", i),     32'(bus.overflow), 32'(vecs[i].o));
      check($sformatf("v%0d_illegal", i), 32'(bus.illegal),  32'(vecs[i].il));
      @(posedge clk); #1;
      check($sformatf("v%0d_done_pulse", i), 32'(bus.done), 32'd0);
      check($sformatf("v%0d_busy_off", i),   32'(bus.busy), 32'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check($sformatf("v%0d_hold", i), bus.result, vecs[i].res);
    end

    // Second start while busy must be ignored.
    ndone = 0;
    rdone = '0;
    bus.start = 1'b1;
    bus.funct = FN_ADD;
    bus.a     = 32'd3;
    bus.b     = 32'd4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      if (k == 5) begin
        bus.start = 1'b1;
        bus.funct = FN_SUB;
        bus.a     = 32'd100;
        bus.b     = 32'd1;
      end
      if (k == 6) bus.start = 1'b0;
      if (k == 33) bus.start = 1'b1;
      if (k == 34) bus.start = 1'b0;
      if (bus.done) begin
        ndone++;
        rdone = bus.result;
      end
      @(posedge clk); #1;
    end
    check("busy_ign_ndone",  32'(ndone), 32'd1);
    check("busy_ign_result", rdone,      32'd7);

    // Reset during bit 10 of an add.
    bus.start = 1'b1;
    bus.funct = FN_ADD;
    bus.a     = 32'd20;
    bus.b     = 32'd22;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 1; k < 11; k++) begin
      @(posedge clk); #1;
    end
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",    32'(bus.busy),     32'd0);
    check("mid_rst_done",    32'(bus.done),     32'd0);
    check("mid_rst_result",  bus.result,        32'd0);
    check("mid_rst_zero",    32'(bus.zero),     32'd0);
    check("mid_rst_ovf",     32'(bus.overflow), 32'd0);
    check("mid_rst_illegal", 32'(bus.illegal),  32'd0);
    #2;
    rst_n = 1'b1;
    ndone = 0;
    @(posedge clk); #1;
    for (int k = 0; k < 40; k++) begin
      if (bus.done || bus.busy) ndone++;
      @(posedge clk); #1;
    end
    check("post_rst_quiet", 32'(ndone), 32'd0);

    run_op(FN_ADD, 32'd20, 32'd22, lat, nbusy, ill1, res1);
    check("post_rst_latency", 32'(lat),          32'd33);
    check("post_rst_result",  bus.result,        32'd42);
    check("post_rst_zero",    32'(bus.zero),     32'd0);
    check("post_rst_ovf",     32'(bus.overflow), 32'd0);
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
